// File: rtl/dmem_pkg.sv
// dmem_responder shared types and helpers.
// Optional build macro: DMEM_ZERO_WAIT_EN (see dmem_responder).
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam int BE_W   = 4;
    localparam int WORD_W = 32;

    function automatic logic word_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned depth
    );
        logic [31:0] widx;
        widx = (addr - base) >> 2;
        return widx < depth;
    endfunction

    function automatic logic [WORD_W-1:0] be_merge(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] m;
        m = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array, byte-write enables, registered read.
// Storage is intentionally not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk_i,
    input  logic                           en_i,
    input  logic                           we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  logic [BE_W-1:0]                be_i,
    input  logic [WORD_W-1:0]              wdata_i,
    output logic [WORD_W-1:0]              rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[idx_i] <= be_merge(mem_q[idx_i], wdata_i, be_i);
            end
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data memory responder with valid/ready channels.
// Define DMEM_ZERO_WAIT_EN to drop the WAIT state (fixed 1-cycle latency).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        err_q, err_d;
    logic        ld_q, ld_d;
`ifndef DMEM_ZERO_WAIT_EN
    logic [3:0]  cnt_q, cnt_d;
`endif

    logic             in_idle;
    logic             acc_en;
    logic             acc_wr;
    logic             acc_err;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_be;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      arr_rdata;

    // Zero-wait accesses use the live request; delayed ones the captured copy.
    assign in_idle   = (state_q == IDLE);
    assign acc_wr    = in_idle ? req_write : wr_q;
    assign acc_addr  = in_idle ? req_addr  : addr_q;
    assign acc_wdata = in_idle ? req_wdata : wdata_q;
    assign acc_be    = in_idle ? req_be    : be_q;
    assign acc_idx   = IDX_W'((acc_addr - BASE_ADDR) >> 2);
    assign acc_err   = (acc_addr[1:0] != 2'b00) ||
                       !word_in_range(acc_addr, BASE_ADDR, DEPTH_WORDS);

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        err_d     = err_q;
        ld_d      = ld_q;
        acc_en    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
`ifndef DMEM_ZERO_WAIT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
`ifdef DMEM_ZERO_WAIT_EN
                    acc_en  = 1'b1;
                    state_d = RESP;
`else
                    if (WAIT_STATES == 0) begin
                        acc_en  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = 4'(WAIT_STATES - 1);
                        state_d = WAIT;
                    end
`endif
                end
            end
`ifndef DMEM_ZERO_WAIT_EN
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    acc_en  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                    ld_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (acc_en) begin
            err_d = acc_err;
            ld_d  = !acc_wr && !acc_err;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            ld_q    <= 1'b0;
`ifndef DMEM_ZERO_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
            ld_q    <= ld_d;
`ifndef DMEM_ZERO_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk_i  (Clk),
        .en_i   (acc_en),
        .we_i   (acc_en && acc_wr && !acc_err),
        .idx_i  (acc_idx),
        .be_i   (acc_be),
        .wdata_i(acc_wdata),
        .rdata_o(arr_rdata)
    );

    // Read register only changes on an access, so gating keeps it stable.
    assign rsp_rdata = ld_q ? arr_rdata : 32'h0;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder.
// Honours DMEM_ZERO_WAIT_EN for the expected latency.
module tb_dmem_responder;

    localparam int          DEPTH = 256;
    localparam int          WS    = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef DMEM_ZERO_WAIT_EN
    localparam int LAT_K = 1;
`else
    localparam int LAT_K = WS + 1;
`endif

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_ready = 1'b1;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          checks = 0;
    int          failures = 0;

    always #5 Clk = ~Clk;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES(WS),
        .BASE_ADDR  (BASE)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    task automatic predict(input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        exp_t        e;
        logic [31:0] widx;
        widx = (a - BASE) >> 2;
        e.rdata = 32'h0;
        e.err   = (a[1:0] != 2'b00) || (widx >= DEPTH);
        if (!e.err) begin
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) model[widx][8*i +: 8] = d[8*i +: 8];
            end else begin
                e.rdata = model[widx];
            end
        end
        sb.push_back(e);
    endtask

    task automatic xact(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input int hold);
        int   k;
        exp_t e;
        @(negedge Clk);
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge Clk);
            k++;
        end
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        predict(w, a, d, be);
        rsp_ready = (hold == 0);
        @(negedge Clk);
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = 32'h0000_0004;
        req_wdata = $urandom;
        req_be    = 4'hF;
        k = 1;
        while (!rsp_valid && k < LAT_K + 20) begin
            @(negedge Clk);
            k++;
        end
        checks++;
        if (!rsp_valid) begin
            failures++;
            $display("FAIL rsp_timeout addr=%h: no rsp_valid after %0d cycles", a, k);
            sb.delete();
            rsp_ready = 1'b1;
            return;
        end
        if (k != LAT_K) begin
            failures++;
            $display("FAIL latency addr=%h: got %0d want %0d", a, k, LAT_K);
        end
        e = sb.pop_front();
        checks++;
        if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
            failures++;
            $display("FAIL rsp addr=%h: rdata=%h err=%b want rdata=%h err=%b",
                     a, rsp_rdata, rsp_err, e.rdata, e.err);
        end
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(negedge Clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata ||
                rsp_err !== e.err || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold%0d: v=%b rdata=%h err=%b rdy=%b want 1 %h %b 0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready, e.rdata, e.err);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge Clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 ||
            rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL release: v=%b rdy=%b rdata=%h err=%b want 0 1 0 0",
                     rsp_valid, req_ready, rsp_rdata, rsp_err);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
            rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL %s: rdy=%b v=%b rdata=%h err=%b want 1 0 0 0",
                     tag, req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_reset;
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        check_idle_outputs("reset");
        Rst = 1'b1;
        @(negedge Clk);
        check_idle_outputs("post_reset");
    endtask

    task automatic test_store_load;
        xact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0);
    endtask

    task automatic test_byte_merge;
        xact(1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0);
        xact(1'b0, 32'h10, 32'h0, 4'hF, 0);
        xact(1'b0, 32'h10, 32'h0, 4'b0000, 0);
    endtask

    task automatic test_errors;
        xact(1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, 0);
        xact(1'b0, 32'h13, 32'h0, 4'hF, 0);
        xact(1'b1, BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, 0);
        xact(1'b1, 32'h2, 32'h5555_5555, 4'hF, 0);
        xact(1'b0, 32'h0, 32'h0, 4'hF, 0);
        xact(1'b1, 32'h0, 32'h7777_7777, 4'h0, 0);
        xact(1'b0, 32'h0, 32'h0, 4'hF, 0);
        xact(1'b1, 32'h3FC, 32'hA5A5_0FF0, 4'hF, 0);
        xact(1'b0, 32'h3FC, 32'h0, 4'hF, 0);
        xact(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 0);
    endtask

    task automatic test_backpressure;
        xact(1'b0, 32'h10, 32'h0, 4'hF, 5);
        xact(1'b1, 32'h14, 32'h1234_5678, 4'hC, 3);
    endtask

    task automatic test_reset_midop;
        xact(1'b1, 32'h20, 32'h0, 4'hF, 0);
        @(negedge Clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFE_F00D;
        req_be    = 4'hF;
        @(negedge Clk);
        req_valid = 1'b0;
        // With no WAIT stage the store has already completed here.
        if (LAT_K == 1) model[8] = 32'hCAFE_F00D;
        Rst = 1'b0;
        #1;
        check_idle_outputs("reset_midop");
        @(negedge Clk);
        Rst = 1'b1;
        xact(1'b0, 32'h20, 32'h0, 4'hF, 0);
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [4];
        int          cyc, last, seen, issued;
        logic        will_acc;
        exp_t        e;
        addrs[0] = 32'h10;
        addrs[1] = 32'h20;
        addrs[2] = 32'h3FC;
        addrs[3] = 32'h0;
        rsp_ready = 1'b1;
        @(negedge Clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_be    = 4'hF;
        req_addr  = addrs[0];
        predict(1'b0, addrs[0], 32'h0, 4'hF);
        issued = 1;
        seen = 0;
        last = -1;
        cyc = 0;
        while (seen < 4 && cyc < 200) begin
            will_acc = req_valid && req_ready;
            @(negedge Clk);
            cyc++;
            if (will_acc) begin
                if (issued < 4) begin
                    req_addr = addrs[issued];
                    predict(1'b0, addrs[issued], 32'h0, 4'hF);
                    issued++;
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (rsp_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra: unexpected response rdata=%h", rsp_rdata);
                end else begin
                    e = sb.pop_front();
                    if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                        failures++;
                        $display("FAIL b2b_rsp%0d: rdata=%h err=%b want %h %b",
                                 seen, rsp_rdata, rsp_err, e.rdata, e.err);
                    end
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != LAT_K + 1) begin
                        failures++;
                        $display("FAIL b2b_spacing%0d: got %0d want %0d",
                                 seen, cyc - last, LAT_K + 1);
                    end
                end
                last = cyc;
                seen++;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (seen != 4) begin
            failures++;
            $display("FAIL b2b_count: got %0d want 4", seen);
        end
        sb.delete();
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_byte_merge;
        test_errors;
        test_backpressure;
        test_reset_midop;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the MIPS32 data path.
- Accepts load/store requests from the core-side initiator over a valid/ready request channel.
- Inserts a programmable number of wait states, performs the word access with byte enables on an internal array, and returns the result over a valid/ready response channel.
- Replaces the zero-latency data memory once the core gains a stall-capable memory interface.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of two, ≥4).
- WAIT_STATES, 2, cycles spent in WAIT between acceptance and response (0..15).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; bit i covers wdata[8i+7:8i].
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range access.

Behaviour:
- Reset (Rst=0, async): state=IDLE, wait counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, captured request regs=0. Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, capture write/addr/wdata/be.
  - If WAIT_STATES>0: load counter with WAIT_STATES-1 and go to WAIT. Otherwise go directly to RESP.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When counter==0, perform the access, register the result, and go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable.
  - On rsp_ready=1, go to IDLE and clear rsp_valid, rsp_rdata and rsp_err the next cycle.
- Access timing: for WAIT_STATES=0 the access happens on the acceptance edge.
- Latency: acceptance at edge N gives rsp_valid high from edge N+1+WAIT_STATES. Minimum request spacing is WAIT_STATES+2 cycles. No acceptance occurs while in WAIT or RESP.
- Address decode:
  - offset = req_addr - BASE_ADDR (32-bit, wraps).
  - word index = offset[31:2].
  - Error if req_addr[1:0]!=0 or word index ≥ DEPTH_WORDS.
- Error response: rsp_err=1, rsp_rdata=0, array unchanged.
- Store: for each i with req_be[i]=1, byte i of the word is replaced; other bytes keep their value. be=4'b0000 is legal, is a no-op, and returns rsp_err=0. rsp_rdata=0.
- Load: rsp_rdata = full stored word regardless of req_be.
- Back-pressure: rsp_ready may stay low indefinitely; outputs hold and no new request is accepted.
- Reset mid-operation: an access still in WAIT is dropped and the array is not written. A completed access stays in the array.
- Inputs are ignored outside IDLE; changes to req_* after acceptance have no effect.

Optional Feature:
- Macro: DMEM_ZERO_WAIT_EN.
- Defined: WAIT_STATES is ignored and treated as 0, the WAIT state and counter are removed, and latency is fixed at 1 cycle (rsp_valid at N+1).
- Undefined: WAIT_STATES applies as specified above.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, WAIT, RESP};
  - BE_W=4, WORD_W=32;
  - function word_in_range(addr, base, depth);
  - function be_merge(old, new, be) returning the merged 32-bit word.
- Sub-module dmem_array: synchronous single-port word array with byte-write enables and registered read; no reset on storage. The FSM, counter and decode stay in dmem_responder.

Test Plan:
- Reset and store/load, WAIT_STATES=2: release Rst. Store addr 0x10, wdata 0xDEADBEEF, be 4'hF accepted at edge 0 → rsp_valid at edge 3, rsp_err=0, rsp_rdata=0. Then load 0x10 → rsp_rdata=0xDEADBEEF.
- Byte merge: word 0x10 = 0xDEADBEEF; store wdata 0x11223344 with be 4'b0101 → load returns 0xDE22BE44.
- Errors:
  - load 0x13 (misaligned) → rsp_err=1, rsp_rdata=0;
  - store to BASE_ADDR+4*DEPTH_WORDS → rsp_err=1, and a following load of word 0 is unchanged.
- Back-pressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid/rsp_rdata stable and req_ready=0 throughout. rsp_ready=1 → IDLE next cycle, req_ready=1.
- Reset mid-op: accept store 0x20 = 0xCAFEF00D, assert Rst in WAIT → outputs at reset values immediately. Load 0x20 then returns its prior value (pre-written 0x0).
- DMEM_ZERO_WAIT_EN defined: accept load at edge N → rsp_valid at edge N+1. With rsp_ready held high, back-to-back loads complete every 2 cycles.
